// File: rtl/ap_ctrl_txn_recorder.sv
`default_nettype none
// ============================================================================
// Module   : ap_ctrl_txn_recorder
// Purpose  : Timestamps ap_ctrl_hs start accepts and completions, pairs them
//            in FIFO order and streams one record per transaction
//            (id, start time, latency, initiation interval, stall).
//            Optional macro TXN_REC_STALL_EN enables the per-start stall
//            counter; when undefined rec_stall is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ap_ctrl_txn_recorder #(
    parameter int TS_W         = 32,
    parameter int ID_W         = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ap_start,
    input  logic                              ap_ready,
    input  logic                              ap_done,
    input  logic                              ap_continue,
    input  logic                              finish,
    output logic                              rec_valid,
    input  logic                              rec_ready,
    output logic [ID_W-1:0]                   rec_txn_id,
    output logic [TS_W-1:0]                   rec_start_ts,
    output logic [TS_W-1:0]                   rec_latency,
    output logic [TS_W-1:0]                   rec_interval,
    output logic [TS_W-1:0]                   rec_stall,
    output logic [TS_W-1:0]                   cycle_count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [15:0]                       drop_count,
    output logic                              err_unmatched_done,
    output logic                              err_inflight_ovf,
    output logic                              drained
);
    localparam int c_QA_W = $clog2(MAX_INFLIGHT);
    localparam int c_QC_W = $clog2(MAX_INFLIGHT+1);
    localparam int c_FA_W = $clog2(FIFO_DEPTH);
    localparam int c_FC_W = $clog2(FIFO_DEPTH+1);
    localparam logic [c_QC_W-1:0] c_Q_FULL = c_QC_W'(MAX_INFLIGHT);
    localparam logic [c_FC_W-1:0] c_F_FULL = c_FC_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]        r_state, w_state_nxt;
    logic              w_run, w_open;
    logic [TS_W-1:0]   r_cycle;
    logic [ID_W-1:0]   r_next_id;
    logic [TS_W-1:0]   r_last_ts;
    logic              r_have_last;
    logic [15:0]       r_drop;
    logic              r_err_unm, r_err_ovf;

    // Outstanding-start queue
    logic [TS_W-1:0]   r_q_ts [MAX_INFLIGHT];
    logic [TS_W-1:0]   r_q_iv [MAX_INFLIGHT];
    logic [ID_W-1:0]   r_q_id [MAX_INFLIGHT];
    logic [c_QA_W-1:0] r_q_wp, r_q_rp;
    logic [c_QC_W-1:0] r_q_cnt;

    // Output record FIFO
    logic [ID_W-1:0]   r_f_id  [FIFO_DEPTH];
    logic [TS_W-1:0]   r_f_ts  [FIFO_DEPTH];
    logic [TS_W-1:0]   r_f_lat [FIFO_DEPTH];
    logic [TS_W-1:0]   r_f_iv  [FIFO_DEPTH];
    logic [c_FA_W-1:0] r_f_wp, r_f_rp;
    logic [c_FC_W-1:0] r_f_cnt;

    logic              w_acc, w_cmp, w_q_empty, w_q_full;
    logic              w_bypass, w_q_pop, w_q_push, w_take;
    logic              w_rec_push, w_f_valid, w_f_full, w_f_pop, w_f_wr, w_f_drop;
    logic [TS_W-1:0]   w_interval;
    logic [ID_W-1:0]   w_rec_id;
    logic [TS_W-1:0]   w_rec_ts, w_rec_lat, w_rec_iv;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: events are honoured up to and including the finish cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  w_state_nxt = c_S_RUN;
            c_S_RUN:   if (finish) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN: if (r_f_cnt == '0) w_state_nxt = c_S_DONE;
            default:   w_state_nxt = c_S_DONE;
        endcase
    end

    // State decode
    always_comb begin
        w_run   = 1'b0;
        w_open  = 1'b1;
        drained = 1'b0;
        case (r_state)
            c_S_RUN:  w_run = 1'b1;
            c_S_DONE: begin
                w_open  = 1'b0;
                drained = 1'b1;
            end
            default: ;
        endcase
    end

    // Free-running timestamp counter
    always_ff @(posedge clock) begin
        if (reset) r_cycle <= '0;
        else       r_cycle <= r_cycle + TS_W'(1);
    end

    // Event classification and record source selection
    always_comb begin
        w_acc      = w_run & ap_start & ap_ready;
        w_cmp      = w_run & ap_done & ap_continue;
        w_q_empty  = (r_q_cnt == '0);
        w_q_full   = (r_q_cnt == c_Q_FULL);
        w_interval = r_have_last ? (r_cycle - r_last_ts) : '0;
        // Same-cycle start and done with nothing pending completes immediately
        w_bypass   = w_acc & w_cmp & w_q_empty;
        w_q_pop    = w_cmp & ~w_q_empty;
        w_q_push   = w_acc & ~w_bypass & (~w_q_full | w_q_pop);
        w_take     = w_bypass | w_q_push;
        w_rec_push = w_bypass | w_q_pop;
        w_rec_id   = w_bypass ? r_next_id  : r_q_id[r_q_rp];
        w_rec_ts   = w_bypass ? r_cycle    : r_q_ts[r_q_rp];
        w_rec_iv   = w_bypass ? w_interval : r_q_iv[r_q_rp];
        w_rec_lat  = w_bypass ? '0         : (r_cycle - r_q_ts[r_q_rp]);
        w_f_valid  = (r_f_cnt != '0) & w_open;
        w_f_full   = (r_f_cnt == c_F_FULL);
        w_f_pop    = w_f_valid & rec_ready;
        // A same-cycle pop frees a slot before the push is judged
        w_f_wr     = w_rec_push & (~w_f_full | w_f_pop);
        w_f_drop   = w_rec_push & w_f_full & ~w_f_pop;
    end

    // Transaction id, previous accept time, sticky errors and drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_id   <= '0;
            r_last_ts   <= '0;
            r_have_last <= 1'b0;
            r_err_unm   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_drop      <= '0;
        end else begin
            if (w_take) begin
                r_next_id   <= r_next_id + ID_W'(1);
                r_last_ts   <= r_cycle;
                r_have_last <= 1'b1;
            end
            if (w_cmp & w_q_empty & ~w_acc)
                r_err_unm <= 1'b1;
            if (w_acc & ~w_bypass & w_q_full & ~w_q_pop)
                r_err_ovf <= 1'b1;
            if (w_f_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    // Outstanding-start queue storage
    always_ff @(posedge clock) begin
        if (w_q_push) begin
            r_q_ts[r_q_wp] <= r_cycle;
            r_q_iv[r_q_wp] <= w_interval;
            r_q_id[r_q_wp] <= r_next_id;
        end
    end

    // Outstanding-start queue pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q_wp  <= '0;
            r_q_rp  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_q_push) r_q_wp <= r_q_wp + c_QA_W'(1);
            if (w_q_pop)  r_q_rp <= r_q_rp + c_QA_W'(1);
            case ({w_q_push, w_q_pop})
                2'b10:   r_q_cnt <= r_q_cnt + c_QC_W'(1);
                2'b01:   r_q_cnt <= r_q_cnt - c_QC_W'(1);
                default: ;
            endcase
        end
    end

    // Output FIFO storage
    always_ff @(posedge clock) begin
        if (w_f_wr) begin
            r_f_id[r_f_wp]  <= w_rec_id;
            r_f_ts[r_f_wp]  <= w_rec_ts;
            r_f_lat[r_f_wp] <= w_rec_lat;
            r_f_iv[r_f_wp]  <= w_rec_iv;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_f_wp  <= '0;
            r_f_rp  <= '0;
            r_f_cnt <= '0;
        end else begin
            if (w_f_wr)  r_f_wp <= r_f_wp + c_FA_W'(1);
            if (w_f_pop) r_f_rp <= r_f_rp + c_FA_W'(1);
            case ({w_f_wr, w_f_pop})
                2'b10:   r_f_cnt <= r_f_cnt + c_FC_W'(1);
                2'b01:   r_f_cnt <= r_f_cnt - c_FC_W'(1);
                default: ;
            endcase
        end
    end

`ifdef TXN_REC_STALL_EN
    logic [TS_W-1:0] r_stall_cnt;
    logic [TS_W-1:0] r_q_st [MAX_INFLIGHT];
    logic [TS_W-1:0] r_f_st [FIFO_DEPTH];
    logic [TS_W-1:0] w_rec_stall;

    // Count cycles the pending start waits on ap_ready, saturating
    always_ff @(posedge clock) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_acc || !ap_start)
            r_stall_cnt <= '0;
        else if (w_run && !ap_ready && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + TS_W'(1);
    end

    // Stall value follows its transaction through both queues
    always_comb begin
        w_rec_stall = w_bypass ? r_stall_cnt : r_q_st[r_q_rp];
    end

    // Stall field storage alongside the other queue fields
    always_ff @(posedge clock) begin
        if (w_q_push) r_q_st[r_q_wp] <= r_stall_cnt;
        if (w_f_wr)   r_f_st[r_f_wp] <= w_rec_stall;
    end

    assign rec_stall = w_f_valid ? r_f_st[r_f_rp] : '0;
`else
    assign rec_stall = '0;
`endif

    // Record fields read zero whenever no record is offered
    assign rec_valid          = w_f_valid;
    assign rec_txn_id         = w_f_valid ? r_f_id[r_f_rp]  : '0;
    assign rec_start_ts       = w_f_valid ? r_f_ts[r_f_rp]  : '0;
    assign rec_latency        = w_f_valid ? r_f_lat[r_f_rp] : '0;
    assign rec_interval       = w_f_valid ? r_f_iv[r_f_rp]  : '0;
    assign cycle_count        = r_cycle;
    assign inflight           = r_q_cnt;
    assign drop_count         = r_drop;
    assign err_unmatched_done = r_err_unm;
    assign err_inflight_ovf   = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_txn_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_ctrl_txn_recorder
// Purpose  : Directed self-checking bench for ap_ctrl_txn_recorder with a
//            reference model feeding an expected-record scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_txn_recorder;
    localparam int MAX_INFLIGHT = 8;
    localparam int FIFO_DEPTH   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
    logic finish = 1'b0, rec_ready = 1'b0;
    logic        rec_valid, err_unmatched_done, err_inflight_ovf, drained;
    logic [15:0] rec_txn_id, drop_count;
    logic [31:0] rec_start_ts, rec_latency, rec_interval, rec_stall, cycle_count;
    logic [3:0]  inflight;

    // Narrow-counter instance for wrap checking
    logic        s8_start = 1'b0, s8_ready = 1'b0, s8_done = 1'b0;
    logic        v8, unm8, ovf8, drn8;
    logic [15:0] id8, drop8;
    logic [7:0]  ts8, lat8, iv8, st8, cc8;
    logic [3:0]  inf8;

    ap_ctrl_txn_recorder u_dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_txn_id(rec_txn_id),
        .rec_start_ts(rec_start_ts), .rec_latency(rec_latency),
        .rec_interval(rec_interval), .rec_stall(rec_stall),
        .cycle_count(cycle_count), .inflight(inflight), .drop_count(drop_count),
        .err_unmatched_done(err_unmatched_done), .err_inflight_ovf(err_inflight_ovf),
        .drained(drained)
    );

    ap_ctrl_txn_recorder #(.TS_W(8)) u_dut8 (
        .clock(clock), .reset(reset), .ap_start(s8_start), .ap_ready(s8_ready),
        .ap_done(s8_done), .ap_continue(1'b1), .finish(1'b0),
        .rec_valid(v8), .rec_ready(1'b1), .rec_txn_id(id8),
        .rec_start_ts(ts8), .rec_latency(lat8), .rec_interval(iv8), .rec_stall(st8),
        .cycle_count(cc8), .inflight(inf8), .drop_count(drop8),
        .err_unmatched_done(unm8), .err_inflight_ovf(ovf8), .drained(drn8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] id;
        logic [31:0] ts, lat, iv, st;
    } rec_t;
    typedef struct {
        logic [15:0] id;
        logic [31:0] ts, iv, st;
    } pend_t;

    rec_t  sb[$];
    pend_t pend[$];
    rec_t  mon_e;

    int          n_pass = 0, n_total = 0;
    logic [31:0] tb_cyc = 32'd0;
    logic [15:0] m_id;
    logic [31:0] m_last, m_stall;
    bit          m_have, m_run, m_unm, m_ovf;
    int          m_drop, m_popped;

    // Reference cycle counter
    always @(posedge clock) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Record enters the scoreboard unless the output FIFO would overflow
    task automatic push_out(input rec_t r);
        if (sb.size() < FIFO_DEPTH || (sb.size() > 0 && rec_ready)) sb.push_back(r);
        else m_drop++;
    endtask

    task automatic take(input logic [31:0] ts);
        m_id   = m_id + 16'd1;
        m_last = ts;
        m_have = 1'b1;
    endtask

    // Drive one cycle of handshake inputs and advance the reference model
    task automatic do_cycle(input bit s, input bit r, input bit d);
        pend_t e;
        rec_t  rr;
        bit    acc, cmp;
        logic [31:0] iv, st;
        ap_start = s; ap_ready = r; ap_done = d;
        acc = m_run && s && r;
        cmp = m_run && d && ap_continue;
        iv  = m_have ? tb_cyc - m_last : 32'd0;
        st  = m_stall;
`ifdef TXN_REC_STALL_EN
        if (acc || !s) m_stall = 32'd0;
        else if (m_run && !r && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
        if (acc && cmp && pend.size() == 0) begin
            rr.id = m_id; rr.ts = tb_cyc; rr.lat = 32'd0; rr.iv = iv; rr.st = st;
            push_out(rr);
            take(tb_cyc);
        end else begin
            if (cmp) begin
                if (pend.size() > 0) begin
                    e = pend.pop_front();
                    rr.id = e.id; rr.ts = e.ts; rr.lat = tb_cyc - e.ts; rr.iv = e.iv; rr.st = e.st;
                    push_out(rr);
                end else m_unm = 1'b1;
            end
            if (acc) begin
                if (pend.size() < MAX_INFLIGHT) begin
                    e.id = m_id; e.ts = tb_cyc; e.iv = iv; e.st = st;
                    pend.push_back(e);
                    take(tb_cyc);
                end else m_ovf = 1'b1;
            end
        end
        tick();
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    endtask

    task automatic go_to(input int n);
        while (tb_cyc < n) do_cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; finish = 1'b0;
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sb.delete(); pend.delete();
        m_id = 16'd0; m_last = 32'd0; m_stall = 32'd0; m_have = 1'b0;
        m_unm = 1'b0; m_ovf = 1'b0; m_drop = 0; m_popped = 0; m_run = 1'b0;
        tick();
        m_run = 1'b1;
    endtask

    // Scoreboard consumer: compare each record as the consumer accepts it
    always @(negedge clock) begin
        if (!reset && rec_valid && rec_ready) begin
            if (sb.size() == 0) chk("rec_unexpected", rec_valid, 1'b0);
            else begin
                mon_e = sb.pop_front();
                chk("rec_id",       rec_txn_id,   mon_e.id);
                chk("rec_start_ts", rec_start_ts, mon_e.ts);
                chk("rec_latency",  rec_latency,  mon_e.lat);
                chk("rec_interval", rec_interval, mon_e.iv);
                chk("rec_stall",    rec_stall,    mon_e.st);
                m_popped++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_valid", rec_valid, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_errs", {err_unmatched_done, err_inflight_ovf}, 0);
        chk("rst_drained", drained, 0);
        chk("rst_id", rec_txn_id, 0);

        // Single transaction
        do_reset();
        rec_ready = 1'b1;
        go_to(10); do_cycle(1, 1, 0);
        chk("t1_inflight", inflight, 1);
        go_to(25); do_cycle(0, 0, 1);
        chk("t1_valid_at_26", rec_valid, 1);
        chk("t1_latency", rec_latency, 15);
        do_cycle(0, 0, 0); do_cycle(0, 0, 0);
        chk("t1_count", m_popped, 1);

        // Pipelined
        do_reset();
        go_to(10); do_cycle(1, 1, 0);
        go_to(12); do_cycle(1, 1, 0);
        go_to(14); do_cycle(1, 1, 0);
        chk("t2_inflight_peak", inflight, 3);
        go_to(20); do_cycle(0, 0, 1);
        go_to(22); do_cycle(0, 0, 1);
        go_to(24); do_cycle(0, 0, 1);
        do_cycle(0, 0, 0); do_cycle(0, 0, 0);
        chk("t2_count", m_popped, 3);
        chk("t2_inflight_end", inflight, 0);

        // Backpressure and output FIFO overflow
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1, 1, 0);
            do_cycle(0, 0, 1);
        end
        chk("t3_drop", drop_count, 4);
        chk("t3_drop_model", drop_count, m_drop);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", rec_valid, 1);
            chk("t3_hold_id", rec_txn_id, sb[0].id);
            chk("t3_hold_ts", rec_start_ts, sb[0].ts);
            do_cycle(0, 0, 0);
        end
        rec_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) do_cycle(0, 0, 0);
        chk("t3_drained_sb", sb.size(), 0);
        chk("t3_count", m_popped, 16);
        chk("t3_valid_low", rec_valid, 0);

        // Error flags
        do_reset();
        do_cycle(0, 0, 1);
        chk("t4_unmatched", err_unmatched_done, 1);
        chk("t4_no_record", rec_valid, 0);
        for (int i = 0; i < 9; i++) do_cycle(1, 1, 0);
        chk("t4_ovf", err_inflight_ovf, 1);
        chk("t4_inflight", inflight, 8);
        chk("t4_ovf_no_drop", drop_count, 0);

        // Bypass, overlapped accept/done, and counter wrap on the narrow instance
        do_reset();
        go_to(5); do_cycle(1, 1, 1);
        chk("t5_bypass_valid", rec_valid, 1);
        chk("t5_bypass_lat", rec_latency, 0);
        chk("t5_bypass_inflight", inflight, 0);
        go_to(8);  do_cycle(1, 1, 0);
        go_to(12); do_cycle(1, 1, 1);
        chk("t5_overlap_inflight", inflight, 1);
        go_to(15); do_cycle(0, 0, 1);
        do_cycle(0, 0, 0); do_cycle(0, 0, 0);
        chk("t5_count", m_popped, 3);
        go_to(250);
        s8_start = 1'b1; s8_ready = 1'b1;
        do_cycle(0, 0, 0);
        s8_start = 1'b0; s8_ready = 1'b0;
        go_to(260);
        s8_done = 1'b1;
        do_cycle(0, 0, 0);
        s8_done = 1'b0;
        chk("t5_wrap_valid", v8, 1);
        chk("t5_wrap_ts", ts8, 8'd250);
        chk("t5_wrap_latency", lat8, 8'd10);

        // Stall measurement
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0);
        do_cycle(1, 1, 0);
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0); do_cycle(0, 0, 0);
        chk("t6_count", m_popped, 1);

        // Finish and drain
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 1, 0);
            do_cycle(0, 0, 1);
        end
        finish = 1'b1;
        do_cycle(0, 0, 0);
        m_run = 1'b0;
        chk("t7_not_drained", drained, 0);
        rec_ready = 1'b1;
        for (int i = 0; i < 20 && !drained; i++) do_cycle(0, 0, 0);
        chk("t7_drained", drained, 1);
        chk("t7_count", m_popped, 3);
        do_cycle(1, 1, 1);
        do_cycle(0, 0, 1);
        chk("t7_ignored_unm", err_unmatched_done, 0);
        chk("t7_ignored_inflight", inflight, 0);
        chk("t7_done_valid", rec_valid, 0);
        chk("t7_still_drained", drained, 1);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
